// File: rtl/pc_load_ctrl_pkg.sv
// ============================================================================
// Module   : pc_load_ctrl_pkg
// Purpose  : Shared types and constants for the program-counter load
//            controller (state encoding, default widths, reset vector).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_load_ctrl_pkg;

    localparam int PC_W  = 16;
    localparam int BUS_W = 8;

    localparam logic [PC_W-1:0] DEF_RST_VECTOR = 16'h0000;

    typedef enum logic [2:0] {
        RST  = 3'd0,
        VEC  = 3'd1,
        IDLE = 3'd2,
        JLO  = 3'd3,
        JHI  = 3'd4,
        LOAD = 3'd5,
        IRQ  = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_addr_assembler.sv
// ============================================================================
// Module   : pc_addr_assembler
// Purpose  : Collects a jump target delivered as two bus bytes (low byte
//            first) and presents the assembled address to the controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_addr_assembler
    import pc_load_ctrl_pkg::*;
#(
    parameter int BUSW = BUS_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              capture_lo,
    input  logic              capture_hi,
    input  logic [BUSW-1:0]   data_in,
    output logic [2*BUSW-1:0] target
);

    logic [BUSW-1:0] hold;

    // Low byte waits in hold; the high byte completes the target in one shot
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold   <= '0;
            target <= '0;
        end else begin
            if (capture_lo) hold   <= data_in;
            if (capture_hi) target <= {data_in, hold};
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_load_ctrl.sv
// ============================================================================
// Module   : pc_load_ctrl
// Purpose  : Sequences the ttl_74161 program-counter chain: reset vector,
//            fetch increments, two-byte jumps and (optionally) interrupts.
//            Optional feature macro: PC_LOAD_CTRL_IRQ_EN enables the IRQ path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_load_ctrl
    import pc_load_ctrl_pkg::*;
#(
    parameter int               WIDTH      = PC_W,
    parameter int               BUSW       = BUS_W,
    parameter logic [WIDTH-1:0] RST_VECTOR = DEF_RST_VECTOR
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Inc_req,
    input  logic             Stall,
    input  logic             Jmp_req,
    input  logic [BUSW-1:0]  Jmp_data,
    input  logic             Jmp_valid,
    output logic             Jmp_ready,
    input  logic             Irq_req,
    input  logic [WIDTH-1:0] Irq_vector,
    output logic             PC_Clear_bar,
    output logic             PC_Load_bar,
    output logic             PC_ENT,
    output logic             PC_ENP,
    output logic [WIDTH-1:0] PC_D,
    output logic             Busy,
    output logic             Ack
);

    state_t           state;
    state_t           state_nxt;
    logic             ack_pending;
    logic             ack_set;
    logic             ack_clr;
    logic             capture_lo;
    logic             capture_hi;
    logic [WIDTH-1:0] target;

    pc_addr_assembler #(
        .BUSW (BUSW)
    ) u_asm (
        .Clk        (Clk),
        .Reset      (Reset),
        .capture_lo (capture_lo),
        .capture_hi (capture_hi),
        .data_in    (Jmp_data),
        .target     (target)
    );

`ifdef PC_LOAD_CTRL_IRQ_EN
    logic             irq_take;
    logic [WIDTH-1:0] irq_vec;

    // Vector is captured as IDLE hands over to IRQ so later changes are ignored
    always_ff @(posedge Clk) begin
        if (Reset)         irq_vec <= '0;
        else if (irq_take) irq_vec <= Irq_vector;
    end
`else
    // Interrupt ports stay on the boundary but have no function in this build
    logic unused_irq;
    assign unused_irq = ^{Irq_req, Irq_vector};
`endif

    // State register plus the pending-acknowledge flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= RST;
            ack_pending <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ack_set)      ack_pending <= 1'b1;
            else if (ack_clr) ack_pending <= 1'b0;
        end
    end

    // Next state and counter-chain controls; Stall gates every action except in RST
    always_comb begin
        state_nxt    = state;
        PC_Clear_bar = 1'b1;
        PC_Load_bar  = 1'b1;
        PC_ENT       = 1'b0;
        PC_ENP       = 1'b0;
        PC_D         = '0;
        Jmp_ready    = 1'b0;
        Busy         = 1'b1;
        Ack          = 1'b0;
        ack_set      = 1'b0;
        ack_clr      = 1'b0;
        capture_lo   = 1'b0;
        capture_hi   = 1'b0;
`ifdef PC_LOAD_CTRL_IRQ_EN
        irq_take     = 1'b0;
`endif
        case (state)
            RST: begin
                PC_Clear_bar = 1'b0;
                state_nxt    = VEC;
            end
            VEC: begin
                PC_D = RST_VECTOR;
                if (!Stall) begin
                    PC_Load_bar = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            IDLE: begin
                Busy = 1'b0;
                if (!Stall) begin
                    Ack     = ack_pending;
                    ack_clr = 1'b1;
`ifdef PC_LOAD_CTRL_IRQ_EN
                    if (Irq_req) begin
                        irq_take  = 1'b1;
                        state_nxt = IRQ;
                    end else
`endif
                    if (Jmp_req) begin
                        state_nxt = JLO;
                    end else if (Inc_req) begin
                        // Only request-to-output path: increment at this very edge
                        PC_ENT = 1'b1;
                        PC_ENP = 1'b1;
                    end
                end
            end
            JLO: begin
                if (!Stall) begin
                    Jmp_ready = 1'b1;
                    if (Jmp_valid) begin
                        capture_lo = 1'b1;
                        state_nxt  = JHI;
                    end
                end
            end
            JHI: begin
                if (!Stall) begin
                    Jmp_ready = 1'b1;
                    if (Jmp_valid) begin
                        capture_hi = 1'b1;
                        state_nxt  = LOAD;
                    end
                end
            end
            LOAD: begin
                PC_D = target;
                if (!Stall) begin
                    PC_Load_bar = 1'b0;
                    ack_set     = 1'b1;
                    state_nxt   = IDLE;
                end
            end
`ifdef PC_LOAD_CTRL_IRQ_EN
            IRQ: begin
                PC_D = irq_vec;
                if (!Stall) begin
                    PC_Load_bar = 1'b0;
                    ack_set     = 1'b1;
                    state_nxt   = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = RST;
            end
        endcase
    end

endmodule

`default_nettype wire
